fetch_drain_ctrl: RTL and testbench
===================================

FETCH_DRAIN_CTRL -- requirements
Module: fetch_drain_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC width.
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000000, instruction word injected during drain.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 10, range 1-255, number of forced-NOP cycles before done.
REQ-004 SHALL have parameter PROG_INTERVAL, default 64, power of two, unique-PC count between progress pulses.
REQ-005 SHALL have parameter CNT_W, default 32, width of unique-PC and timeout counters.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 2000000; 0 disables timeout.
REQ-007 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port enable, input, 1, start request, sampled only in IDLE.
REQ-010 SHALL have port pc_f, input, XLEN, fetch-stage PC.
REQ-011 SHALL have port instr_in, input, 32, fetched instruction from instruction memory.
REQ-012 SHALL have port end_instr, input, 32, last-instruction word to detect, held stable while running.
REQ-013 SHALL have port stall_f, input, 1, fetch stall; high means the fetch slot is not consumed.
REQ-014 SHALL have port instr_out, output, 32, instruction word delivered to decode.
REQ-015 SHALL have port nop_force, output, 1, high while NOPs are injected.
REQ-016 SHALL have port unique_pc_count, output, CNT_W, count of distinct consecutive fetch PCs.
REQ-017 SHALL have port progress_pulse, output, 1, one-cycle strobe per PROG_INTERVAL unique PCs.
REQ-018 SHALL have port last_detected, output, 1, sticky flag set when end_instr is fetched.
REQ-019 SHALL have port drain_count, output, 8, forced-NOP cycles elapsed.
REQ-020 SHALL have ports done and timeout, output, 1 each, sticky terminal flags.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DRAIN, DONE, TOUT.
REQ-022 SHALL go IDLE->RUN on the first rising edge with enable=1.
REQ-023 SHALL drive instr_out combinationally as NOP_WORD when nop_force=1, otherwise instr_in, with zero latency.
REQ-024 SHALL drive nop_force=1 in DRAIN, DONE and TOUT, and 0 in IDLE and RUN.
REQ-025 SHALL, in RUN with stall_f=0, instr_in!=NOP_WORD and pc_f!=last_pc, increment unique_pc_count and load last_pc<=pc_f.
REQ-026 SHALL saturate unique_pc_count at all-ones.
REQ-027 SHALL assert progress_pulse for exactly one cycle, in the cycle after unique_pc_count becomes a nonzero multiple of PROG_INTERVAL.
REQ-028 SHALL, in RUN with stall_f=0, instr_in==end_instr and instr_in!=NOP_WORD, set last_detected, clear drain_count and enter DRAIN on the same edge; the unique-PC update of REQ-025 also applies on that edge.
REQ-029 SHALL never detect end_instr==NOP_WORD; the block then stays in RUN until timeout.
REQ-030 SHALL increment drain_count every cycle in DRAIN regardless of stall_f, and enter DONE on the edge where drain_count becomes DRAIN_CYCLES; nop_force is high for exactly DRAIN_CYCLES cycles before done rises.
REQ-031 SHALL hold done=1 in DONE, with all counters frozen, until reset.
REQ-032 SHALL, when TIMEOUT_CYCLES!=0, count cycles spent in RUN plus DRAIN; on reaching TIMEOUT_CYCLES it SHALL enter TOUT and set timeout=1, with all counters frozen until reset.
REQ-033 SHALL give timeout priority over both detection and drain completion when they occur on the same edge.
REQ-034 SHALL ignore enable outside IDLE.

Reset
REQ-035 SHALL, while reset=0 and asynchronously, force state IDLE and all outputs 0 (instr_out follows instr_in), and set last_pc to all-ones.
REQ-036 SHALL, on reset assertion mid-DRAIN or in DONE, drop nop_force immediately, without waiting for clk.
REQ-037 SHALL, after reset deassertion, wait for enable before leaving IDLE.

Verification
REQ-038 SHALL cover: PCs 0,4,8 with non-NOP instructions, then end_instr at PC 0xC -> unique_pc_count=4, last_detected=1, then 10 cycles of nop_force=1 with instr_out=0, then done=1.
REQ-039 SHALL cover: the same PC held for 3 cycles -> unique_pc_count increments once.
REQ-040 SHALL cover: 64 distinct PCs -> a single one-cycle progress_pulse; 128 PCs -> exactly two pulses.
REQ-041 SHALL cover: end_instr presented while stall_f=1 -> no detection; the same word with stall_f=0 -> DRAIN entered.
REQ-042 SHALL cover: TIMEOUT_CYCLES=20 with end_instr never fetched -> timeout=1 at cycle 20 after enable, nop_force=1, done=0.
REQ-043 SHALL cover: reset asserted at drain_count=5 -> nop_force=0 asynchronously, drain_count=0, state IDLE.

Source files
------------

// File: rtl/fetch_drain_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_drain_ctrl
//
// Purpose:
//   Watches the fetch stage of a core while a program runs. It counts
//   distinct consecutive fetch PCs and emits a progress strobe every
//   PROG_INTERVAL of them. It also detects the program's last instruction.
//   After that instruction it injects NOP_WORD into decode for DRAIN_CYCLES
//   cycles, so the pipeline empties, and then raises a sticky done flag.
//   A watchdog moves the block to a sticky timeout state if the run (RUN
//   plus DRAIN) takes too long.
//
// Ports:
//   clk             in   single clock, rising-edge
//   reset           in   asynchronous active-low reset
//   enable          in   start request, sampled only in IDLE
//   pc_f            in   fetch-stage PC (XLEN)
//   instr_in        in   fetched instruction word (32)
//   end_instr       in   last-instruction word to detect (32)
//   stall_f         in   fetch stall: the fetch slot is not consumed
//   instr_out       out  word delivered to decode (NOP_WORD while forcing)
//   nop_force       out  high while NOPs are injected (DRAIN/DONE/TOUT)
//   unique_pc_count out  saturating count of distinct consecutive PCs
//   progress_pulse  out  one-cycle strobe per PROG_INTERVAL unique PCs
//   last_detected   out  sticky: end_instr has been fetched
//   drain_count     out  forced-NOP cycles elapsed (8)
//   done            out  sticky: drain completed
//   timeout         out  sticky: watchdog expired
// ---------------------------------------------------------------------------
module fetch_drain_ctrl #(
  parameter int unsigned XLEN           = 32,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES   = 10,
  parameter int unsigned PROG_INTERVAL  = 64,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [XLEN-1:0]  pc_f,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      end_instr,
  input  logic             stall_f,
  output logic [31:0]      instr_out,
  output logic             nop_force,
  output logic [CNT_W-1:0] unique_pc_count,
  output logic             progress_pulse,
  output logic             last_detected,
  output logic [7:0]       drain_count,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_TOUT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] PROG_MASK = CNT_W'(PROG_INTERVAL - 1);
  localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]       DRAIN_LIM = 8'(DRAIN_CYCLES);
  localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic [CNT_W-1:0] upc_q, upc_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [7:0]       drain_q, drain_d;
  logic             prog_q, prog_d;
  logic             last_det_q, last_det_d;

  logic             fetch_ok;
  logic             tmo_hit;
  logic [CNT_W-1:0] tmo_inc;

  // A fetch slot is "real" only when it is consumed and is not a bubble.
  assign fetch_ok = !stall_f && (instr_in != NOP_WORD);
  assign tmo_inc  = tmo_q + CNT_ONE;
  assign tmo_hit  = TMO_EN && (tmo_inc == TMO_LIM);

  // NOTE: every _d gets its default (hold) first so no path through the
  // case statement leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    last_pc_d  = last_pc_q;
    upc_d      = upc_q;
    tmo_d      = tmo_q;
    drain_d    = drain_q;
    prog_d     = 1'b0;
    last_det_d = last_det_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end

      S_RUN: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          // Watchdog wins over a detection on the same edge.
          state_d = S_TOUT;
        end else begin
          if (fetch_ok && (pc_f != last_pc_q)) begin
            last_pc_d = pc_f;
            if (upc_q != '1) begin
              upc_d  = upc_q + CNT_ONE;
              // Strobe only on an actual increment onto a multiple, so a
              // saturated or idle counter never re-fires.
              prog_d = ((upc_d & PROG_MASK) == '0);
            end
          end
          if (fetch_ok && (instr_in == end_instr)) begin
            last_det_d = 1'b1;
            drain_d    = 8'd0;
            state_d    = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          state_d = S_TOUT;
        end else begin
          // Drain progresses every cycle; stalls do not hold it back.
          drain_d = drain_q + 8'd1;
          if (drain_d == DRAIN_LIM) state_d = S_DONE;
        end
      end

      // Terminal states: everything frozen until reset.
      S_DONE, S_TOUT: ;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_pc_q  <= '1;
      upc_q      <= '0;
      tmo_q      <= '0;
      drain_q    <= 8'd0;
      prog_q     <= 1'b0;
      last_det_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_pc_q  <= last_pc_d;
      upc_q      <= upc_d;
      tmo_q      <= tmo_d;
      drain_q    <= drain_d;
      prog_q     <= prog_d;
      last_det_q <= last_det_d;
    end
  end

  // Outputs decode straight from registered state, so an asynchronous reset
  // drops nop_force/done/timeout immediately without a clock.
  assign nop_force       = (state_q == S_DRAIN) || (state_q == S_DONE) ||
                           (state_q == S_TOUT);
  assign instr_out       = nop_force ? NOP_WORD : instr_in;
  assign done            = (state_q == S_DONE);
  assign timeout         = (state_q == S_TOUT);
  assign unique_pc_count = upc_q;
  assign progress_pulse  = prog_q;
  assign last_detected   = last_det_q;
  assign drain_count     = drain_q;

endmodule

// File: tb/tb_fetch_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_drain_ctrl
//
// Directed bench for fetch_drain_ctrl. Instance A uses default parameters;
// instance B shortens the watchdog to 20 cycles. Both share the inputs.
// Inputs are driven 1 ns after the rising edge, outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_fetch_drain_ctrl;

  localparam logic [31:0] END_W = 32'h0000_006F;
  localparam logic [31:0] ALU_W = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] pc_f;
  logic [31:0] instr_in;
  logic [31:0] end_instr;
  logic        stall_f;

  logic [31:0] a_instr_out, b_instr_out;
  logic        a_nop, b_nop;
  logic [31:0] a_upc, b_upc;
  logic        a_prog, b_prog;
  logic        a_last, b_last;
  logic [7:0]  a_drain, b_drain;
  logic        a_done, b_done;
  logic        a_tout, b_tout;

  int n_run  = 0;
  int n_fail = 0;

  fetch_drain_ctrl u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .pc_f(pc_f),
    .instr_in(instr_in), .end_instr(end_instr), .stall_f(stall_f),
    .instr_out(a_instr_out), .nop_force(a_nop), .unique_pc_count(a_upc),
    .progress_pulse(a_prog), .last_detected(a_last), .drain_count(a_drain),
    .done(a_done), .timeout(a_tout)
  );

  fetch_drain_ctrl #(.TIMEOUT_CYCLES(20)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .pc_f(pc_f),
    .instr_in(instr_in), .end_instr(end_instr), .stall_f(stall_f),
    .instr_out(b_instr_out), .nop_force(b_nop), .unique_pc_count(b_upc),
    .progress_pulse(b_prog), .last_detected(b_last), .drain_count(b_drain),
    .done(b_done), .timeout(b_tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b0;
    stall_f   = 1'b0;
    pc_f      = 32'd0;
    instr_in  = 32'd0;
    end_instr = END_W;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Enable edge: IDLE -> RUN. Nothing is counted on this edge.
  task automatic start_run();
    enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    instr_in = 32'hDEAD_BEEF;
    #1;
    n_run++; if (a_nop !== 1'b0) begin n_fail++; $display("FAIL reset_nop: got %b want 0", a_nop); end
    n_run++; if (a_instr_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reset_instr_out: got %h want deadbeef", a_instr_out); end
    n_run++; if ({a_upc, a_drain, a_prog, a_last, a_done, a_tout} !== '0) begin n_fail++; $display("FAIL reset_outputs: upc=%0d drain=%0d prog=%b last=%b done=%b tout=%b want all 0", a_upc, a_drain, a_prog, a_last, a_done, a_tout); end
    do_reset();
    // Without enable, the block must stay in IDLE and count nothing.
    instr_in = ALU_W;
    for (int i = 1; i <= 3; i++) begin
      pc_f = 32'(i * 4);
      step();
    end
    n_run++; if (a_nop !== 1'b0 || a_upc !== 32'd0) begin n_fail++; $display("FAIL idle_hold: nop=%b upc=%0d want 0/0", a_nop, a_upc); end
  endtask

  task automatic test_basic_drain();
    int nop_cycles;
    do_reset();
    pc_f     = 32'h0;
    instr_in = ALU_W;
    start_run();
    n_run++; if (a_nop !== 1'b0 || a_upc !== 32'd0) begin n_fail++; $display("FAIL basic_start: nop=%b upc=%0d want 0/0", a_nop, a_upc); end
    step();                                  // PC 0
    pc_f = 32'h4; step();
    pc_f = 32'h8; step();
    n_run++; if (a_upc !== 32'd3) begin n_fail++; $display("FAIL basic_upc3: got %0d want 3", a_upc); end
    pc_f = 32'hC; instr_in = END_W; step();  // detection edge
    n_run++; if (a_upc !== 32'd4) begin n_fail++; $display("FAIL basic_upc4: got %0d want 4", a_upc); end
    n_run++; if (a_last !== 1'b1) begin n_fail++; $display("FAIL basic_last: got %b want 1", a_last); end
    instr_in = 32'hFFFF_FFFF;
    #1;
    n_run++; if (a_instr_out !== 32'h0) begin n_fail++; $display("FAIL basic_nop_word: got %h want 00000000", a_instr_out); end
    nop_cycles = (a_nop && !a_done) ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin
      stall_f = i[0];                        // stalls must not slow the drain
      pc_f    = 32'h100 + 32'(i * 4);
      step();
      if (a_nop && !a_done) nop_cycles++;
      n_run++; if (a_drain !== 8'(i)) begin n_fail++; $display("FAIL drain_count_%0d: got %0d want %0d", i, a_drain, i); end
      n_run++; if (a_done !== (i == 10)) begin n_fail++; $display("FAIL drain_done_%0d: got %b want %b", i, a_done, (i == 10)); end
    end
    stall_f = 1'b0;
    n_run++; if (nop_cycles !== 10) begin n_fail++; $display("FAIL drain_nop_cycles: got %0d want 10", nop_cycles); end
    instr_in = ALU_W;
    for (int i = 0; i < 3; i++) begin
      pc_f = 32'h400 + 32'(i * 4);
      step();
    end
    n_run++; if (a_done !== 1'b1 || a_nop !== 1'b1 || a_upc !== 32'd4 || a_drain !== 8'd10) begin n_fail++; $display("FAIL done_frozen: done=%b nop=%b upc=%0d drain=%0d want 1/1/4/10", a_done, a_nop, a_upc, a_drain); end
  endtask

  task automatic test_same_pc();
    do_reset();
    pc_f     = 32'h100;
    instr_in = ALU_W;
    start_run();
    repeat (3) step();
    n_run++; if (a_upc !== 32'd1) begin n_fail++; $display("FAIL same_pc: got %0d want 1", a_upc); end
    pc_f = 32'h104; step();
    n_run++; if (a_upc !== 32'd2) begin n_fail++; $display("FAIL next_pc: got %0d want 2", a_upc); end
    pc_f = 32'h108; instr_in = 32'h0; step();   // bubble: not counted
    n_run++; if (a_upc !== 32'd2) begin n_fail++; $display("FAIL nop_not_counted: got %0d want 2", a_upc); end
    pc_f = 32'h10C; instr_in = ALU_W; stall_f = 1'b1; step();
    n_run++; if (a_upc !== 32'd2) begin n_fail++; $display("FAIL stall_not_counted: got %0d want 2", a_upc); end
    stall_f = 1'b0; step();
    n_run++; if (a_upc !== 32'd3) begin n_fail++; $display("FAIL unstall_counted: got %0d want 3", a_upc); end
  endtask

  task automatic test_progress();
    int pulses, at62, at66, consec;
    logic prev;
    do_reset();
    instr_in = ALU_W;
    pc_f     = 32'h0;
    start_run();
    pulses = 0; at62 = 0; at66 = 0; consec = 0; prev = 1'b0;
    for (int i = 0; i < 130; i++) begin
      pc_f = (i < 128) ? 32'(i * 4) : 32'(127 * 4);
      step();
      if (a_prog) pulses++;
      if (a_prog && prev) consec++;
      prev = a_prog;
      if (i == 62) at62 = pulses;
      if (i == 65) at66 = pulses;
    end
    n_run++; if (at62 !== 0) begin n_fail++; $display("FAIL prog_early: got %0d pulses want 0", at62); end
    n_run++; if (at66 !== 1) begin n_fail++; $display("FAIL prog_64: got %0d pulses want 1", at66); end
    n_run++; if (pulses !== 2) begin n_fail++; $display("FAIL prog_128: got %0d pulses want 2", pulses); end
    n_run++; if (consec !== 0) begin n_fail++; $display("FAIL prog_width: got %0d multi-cycle pulses want 0", consec); end
    n_run++; if (a_upc !== 32'd128) begin n_fail++; $display("FAIL prog_upc: got %0d want 128", a_upc); end
  endtask

  task automatic test_stall_detect();
    do_reset();
    pc_f     = 32'h40;
    instr_in = END_W;
    stall_f  = 1'b1;
    start_run();
    repeat (2) step();
    n_run++; if (a_last !== 1'b0 || a_nop !== 1'b0 || a_upc !== 32'd0) begin n_fail++; $display("FAIL stall_no_detect: last=%b nop=%b upc=%0d want 0/0/0", a_last, a_nop, a_upc); end
    stall_f = 1'b0;
    step();
    n_run++; if (a_last !== 1'b1 || a_nop !== 1'b1 || a_upc !== 32'd1 || a_drain !== 8'd0) begin n_fail++; $display("FAIL unstall_detect: last=%b nop=%b upc=%0d drain=%0d want 1/1/1/0", a_last, a_nop, a_upc, a_drain); end
  endtask

  task automatic test_end_is_nop();
    do_reset();
    end_instr = 32'h0;
    instr_in  = 32'h0;
    pc_f      = 32'h80;
    start_run();
    repeat (5) step();
    n_run++; if (b_last !== 1'b0 || b_nop !== 1'b0 || b_tout !== 1'b0) begin n_fail++; $display("FAIL end_is_nop: last=%b nop=%b tout=%b want 0/0/0", b_last, b_nop, b_tout); end
  endtask

  task automatic test_timeout();
    do_reset();
    instr_in = ALU_W;
    pc_f     = 32'h200;
    start_run();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 19) begin
        n_run++; if (b_tout !== 1'b0) begin n_fail++; $display("FAIL tout_early: got %b want 0", b_tout); end
      end
    end
    n_run++; if (b_tout !== 1'b1) begin n_fail++; $display("FAIL tout_20: got %b want 1", b_tout); end
    n_run++; if (b_nop !== 1'b1 || b_done !== 1'b0 || b_instr_out !== 32'h0) begin n_fail++; $display("FAIL tout_outputs: nop=%b done=%b instr_out=%h want 1/0/00000000", b_nop, b_done, b_instr_out); end
    pc_f = 32'h204; step();
    pc_f = 32'h208; step();
    n_run++; if (b_tout !== 1'b1 || b_upc !== 32'd1) begin n_fail++; $display("FAIL tout_frozen: tout=%b upc=%0d want 1/1", b_tout, b_upc); end
  endtask

  task automatic test_timeout_priority();
    do_reset();
    instr_in = ALU_W;
    pc_f     = 32'h300;
    start_run();
    repeat (19) step();
    instr_in = END_W;
    pc_f     = 32'h304;
    step();                                   // 20th cycle: detect and expire
    n_run++; if (b_tout !== 1'b1 || b_last !== 1'b0 || b_done !== 1'b0) begin n_fail++; $display("FAIL tout_priority: tout=%b last=%b done=%b want 1/0/0", b_tout, b_last, b_done); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    pc_f     = 32'h40;
    instr_in = END_W;
    start_run();
    step();                                   // detection
    instr_in = ALU_W;
    repeat (5) step();
    n_run++; if (a_drain !== 8'd5 || a_nop !== 1'b1) begin n_fail++; $display("FAIL mid_drain: drain=%0d nop=%b want 5/1", a_drain, a_nop); end
    #2;
    reset = 1'b0;
    #1;                                       // no clock edge in between
    n_run++; if (a_nop !== 1'b0 || a_drain !== 8'd0 || a_last !== 1'b0 || a_upc !== 32'd0) begin n_fail++; $display("FAIL async_reset: nop=%b drain=%0d last=%b upc=%0d want 0/0/0/0", a_nop, a_drain, a_last, a_upc); end
    n_run++; if (a_instr_out !== ALU_W) begin n_fail++; $display("FAIL async_instr_out: got %h want %h", a_instr_out, ALU_W); end
    step();
    reset = 1'b1;
    pc_f = 32'h50; step();
    pc_f = 32'h54; step();
    n_run++; if (a_nop !== 1'b0 || a_upc !== 32'd0) begin n_fail++; $display("FAIL post_reset_idle: nop=%b upc=%0d want 0/0", a_nop, a_upc); end
    start_run();
    pc_f = 32'h58; step();
    n_run++; if (a_upc !== 32'd1) begin n_fail++; $display("FAIL post_reset_run: upc=%0d want 1", a_upc); end
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    stall_f   = 1'b0;
    pc_f      = 32'd0;
    instr_in  = 32'd0;
    end_instr = END_W;
    #3;
    test_reset();
    test_basic_drain();
    test_same_pc();
    test_progress();
    test_stall_detect();
    test_end_is_nop();
    test_timeout();
    test_timeout_priority();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
